dmem_arbiter: RTL

- Shares the single-port data memory (32-bit words, synchronous read, 1-cycle read latency) between two requesters.
- Port 0 is the CPU load/store stage. Port 1 is the program/data loader (DMA-style initialiser or debug access).
- Port 0 has fixed priority, bounded by a starvation guard that forces a port 1 grant after STARVE_LIMIT consecutive port 0 wins.
- Sits between the CPU memory stage, the loader, and the data_memory instance inside the processor top.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, write-first data memory between the CPU
// load/store stage (port 0) and the loader (port 1). Port 0 wins by default;
// a starvation guard hands port 1 one grant after STARVE_LIMIT consecutive
// port 0 wins while port 1 was waiting. Reads return one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic rd_pend;
  logic rd_own;

  // Arbitration: port 0 first unless port 1 has waited LIMIT port-0 wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || (starve_cnt < LIMIT))) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory request mux; idle cycles drive zeros so unrequested inputs never leak.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_en    = 1'b1;
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Consecutive port-0 wins while port 1 waits; cleared once port 1 is served or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (gnt1 || !req1) begin
      starve_cnt <= 4'd0;
    end else if (gnt0 && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Track the owner of an outstanding read; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_own  <= 1'b0;
    end else begin
      rd_pend <= (gnt0 && !we0) || (gnt1 && !we1);
      if ((gnt0 && !we0) || (gnt1 && !we1)) begin
        rd_own <= gnt1;
      end
    end
  end

  // Steer returning read data to its owner; the other port sees zeros.
  always_comb begin
    rvalid0 = rd_pend && !rd_own;
    rvalid1 = rd_pend && rd_own;
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;
  end

endmodule
